// File: rtl/wresp_arbiter.sv
// Registered round-robin arbiter/router for the AXI write-response (B) channel: slaves S0/S1/DS to masters M0/M1.
// Optional WRESP_DECERR_EN: responses whose BID[7:4] names no master are sunk and flagged on 'unmapped'.
module wresp_arbiter #(
    parameter int ID_BITS  = 4,
    parameter int IDS_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDS_BITS-1:0] S0_BID,
    input  logic [1:0]          S0_BResp,
    input  logic                S0_BValid,
    output logic                S0_BReady,
    input  logic [IDS_BITS-1:0] S1_BID,
    input  logic [1:0]          S1_BResp,
    input  logic                S1_BValid,
    output logic                S1_BReady,
    input  logic [IDS_BITS-1:0] DS_BID,
    input  logic [1:0]          DS_BResp,
    input  logic                DS_BValid,
    output logic                DS_BReady,
`ifdef WRESP_DECERR_EN
    output logic                unmapped,
`endif
    output logic [ID_BITS-1:0]  M0_BID,
    output logic [1:0]          M0_BResp,
    output logic                M0_BValid,
    input  logic                M0_BReady,
    output logic [ID_BITS-1:0]  M1_BID,
    output logic [1:0]          M1_BResp,
    output logic                M1_BValid,
    input  logic                M1_BReady
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [2:0] G_S0 = 3'b001;
    localparam logic [2:0] G_S1 = 3'b010;
    localparam logic [2:0] G_DS = 3'b100;

    logic [0:0] state_q, state_d;
    logic [2:0] grant_q, grant_d;
    logic [2:0] last_q,  last_d;

    logic [2:0]          req;
    logic                busy;
    logic                sel_valid;
    logic [IDS_BITS-1:0] sel_bid;
    logic [1:0]          sel_resp;
    logic                to_m0;
    logic                to_m1;
    logic                dest_ready;

    assign req  = {DS_BValid, S1_BValid, S0_BValid};
    assign busy = (state_q == BUSY);

    always_comb begin
        sel_valid = 1'b0;
        sel_bid   = '0;
        sel_resp  = '0;
        if (grant_q[0]) begin
            sel_valid = S0_BValid;
            sel_bid   = S0_BID;
            sel_resp  = S0_BResp;
        end else if (grant_q[1]) begin
            sel_valid = S1_BValid;
            sel_bid   = S1_BID;
            sel_resp  = S1_BResp;
        end else if (grant_q[2]) begin
            sel_valid = DS_BValid;
            sel_bid   = DS_BID;
            sel_resp  = DS_BResp;
        end
    end

`ifdef WRESP_DECERR_EN
    logic [IDS_BITS-ID_BITS-1:0] dest;
    assign dest     = sel_bid[IDS_BITS-1:ID_BITS];
    assign to_m0    = (dest == '0);
    assign to_m1    = (dest == (IDS_BITS-ID_BITS)'(1));
    assign unmapped = busy & ~to_m0 & ~to_m1 & sel_valid;
`else
    // Only the low bit of the master number routes; the upper bits carry no meaning here.
    logic unused_bid_hi;
    assign unused_bid_hi = ^sel_bid[IDS_BITS-1:ID_BITS+1];
    assign to_m0         = ~sel_bid[ID_BITS];
    assign to_m1         = sel_bid[ID_BITS];
`endif

    // An unmapped response has no master to wait for, so the arbiter itself accepts it.
    assign dest_ready = to_m0 ? M0_BReady : (to_m1 ? M1_BReady : 1'b1);

    assign M0_BValid = busy & to_m0 & sel_valid;
    assign M0_BID    = (busy & to_m0) ? sel_bid[ID_BITS-1:0] : '0;
    assign M0_BResp  = (busy & to_m0) ? sel_resp : 2'b00;
    assign M1_BValid = busy & to_m1 & sel_valid;
    assign M1_BID    = (busy & to_m1) ? sel_bid[ID_BITS-1:0] : '0;
    assign M1_BResp  = (busy & to_m1) ? sel_resp : 2'b00;

    assign S0_BReady = busy & grant_q[0] & dest_ready;
    assign S1_BReady = busy & grant_q[1] & dest_ready;
    assign DS_BReady = busy & grant_q[2] & dest_ready;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        if (state_q == IDLE) begin
            // Search cyclically starting just after the most recently served slave.
            unique case (last_q)
                G_S0: begin
                    if      (req[1]) grant_d = G_S1;
                    else if (req[2]) grant_d = G_DS;
                    else if (req[0]) grant_d = G_S0;
                end
                G_S1: begin
                    if      (req[2]) grant_d = G_DS;
                    else if (req[0]) grant_d = G_S0;
                    else if (req[1]) grant_d = G_S1;
                end
                default: begin
                    if      (req[0]) grant_d = G_S0;
                    else if (req[1]) grant_d = G_S1;
                    else if (req[2]) grant_d = G_DS;
                end
            endcase
            if (req != 3'b000) begin
                state_d = BUSY;
            end
        end else begin
            if (!sel_valid) begin
                state_d = IDLE;
                grant_d = 3'b000;
            end else if (dest_ready) begin
                state_d = IDLE;
                grant_d = 3'b000;
                last_d  = grant_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 3'b000;
            last_q  <= G_DS;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

endmodule
